// File: rtl/kyber_ntt_ctrl.sv
// Sequencer for an in-place 256-point Kyber NTT / inverse NTT driving one CT/GS butterfly
// of latency LAT: read/twiddle addressing, layer sequencing and aligned write-back.
module kyber_ntt_ctrl #(
   parameter int LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        inv,
   output logic        busy,
   output logic        done,
   output logic [7:0]  raddr0,
   output logic [7:0]  raddr1,
   input  logic [11:0] rdata0,
   input  logic [11:0] rdata1,
   output logic [6:0]  zaddr,
   input  logic [11:0] zdata,
   output logic        bf_ct,
   output logic        bf_pwm,
   output logic [11:0] bf_a,
   output logic [11:0] bf_b,
   output logic [11:0] bf_w,
   input  logic [11:0] bf_e,
   input  logic [11:0] bf_o,
   output logic        we,
   output logic [7:0]  waddr0,
   output logic [7:0]  waddr1,
   output logic [11:0] wdata0,
   output logic [11:0] wdata1
);
   localparam int DCW = (LAT < 1) ? 1 : $clog2(LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

   state_t         state_q, state_d;
   logic [2:0]     layer_q, layer_d;
   logic [6:0]     t_q, t_d;
   logic           inv_q, inv_d;
   logic [DCW-1:0] dcnt_q, dcnt_d;

   logic           run;
   logic [2:0]     lgm1;
   logic [3:0]     lg;
   logic [7:0]     len8;
   logic [6:0]     grp;
   logic [7:0]     off8;
   logic [7:0]     r0_c;
   logic [7:0]     r1_c;
   logic [6:0]     z_c;

   logic [LAT:0]   vld_p_q;
   logic [7:0]     wa0_p_q [LAT+1];
   logic [7:0]     wa1_p_q [LAT+1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         layer_q <= '0;
         t_q     <= '0;
         inv_q   <= 1'b0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         layer_q <= layer_d;
         t_q     <= t_d;
         inv_q   <= inv_d;
         dcnt_q  <= dcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      layer_d = layer_q;
      t_d     = t_q;
      inv_d   = inv_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               inv_d   = inv;
               layer_d = '0;
               t_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            t_d = t_q + 7'd1;
            if (t_q == 7'd127) begin
               dcnt_d  = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            dcnt_d = dcnt_q + 1'b1;
            // Hold off the next layer until the last write of this one has landed.
            if (dcnt_q == DCW'(LAT)) begin
               if (layer_q < 3'd6) begin
                  layer_d = layer_q + 3'd1;
                  t_d     = '0;
                  state_d = S_RUN;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign run  = (state_q == S_RUN);
   assign busy = run || (state_q == S_DRAIN);
   assign done = (state_q == S_FIN);

   // Layer length L = 2^lg with lg in 1..7; everything below is shifts and masks.
   assign lgm1 = inv_q ? layer_q : (3'd6 - layer_q);
   assign lg   = {1'b0, lgm1} + 4'd1;
   assign len8 = 8'd1 << lg;
   assign grp  = t_q >> lg;
   assign off8 = {1'b0, t_q} & (len8 - 8'd1);
   assign r0_c = ({1'b0, grp} << (lg + 4'd1)) | off8;
   assign r1_c = r0_c | len8;
   assign z_c  = inv_q ? ((7'h7F >> lgm1) ^ grp) : ((7'd64 >> lgm1) | grp);

   assign raddr0 = run ? r0_c : 8'd0;
   assign raddr1 = run ? r1_c : 8'd0;
   assign zaddr  = run ? z_c  : 7'd0;

   assign bf_ct  = ~inv_q;
   assign bf_pwm = 1'b0;
   assign bf_a   = rdata0;
   assign bf_b   = rdata1;
   assign bf_w   = zdata;

   // p0..pLAT: issue addresses ride along with the RAM read + butterfly latency
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p_q <= '0;
      end else begin
         vld_p_q <= {vld_p_q[LAT-1:0], run};
      end
   end

   always_ff @(posedge clk) begin
      wa0_p_q[0] <= r0_c;
      wa1_p_q[0] <= r1_c;
      for (int k = 1; k <= LAT; k++) begin
         wa0_p_q[k] <= wa0_p_q[k-1];
         wa1_p_q[k] <= wa1_p_q[k-1];
      end
   end

   assign we     = vld_p_q[LAT];
   assign waddr0 = we ? wa0_p_q[LAT] : 8'd0;
   assign waddr1 = we ? wa1_p_q[LAT] : 8'd0;
   assign wdata0 = bf_e;
   assign wdata1 = bf_o;

endmodule
